// File: rtl/exc_commit_ctrl.sv
// Trap commit sequencer: picks one trap event from two commit slots plus an interrupt, strobes the CSR file, flushes, then redirects fetch.
// Optional trap counter output is enabled by defining EXC_COMMIT_CNT_EN.
module exc_commit_ctrl #(
    parameter int EXC_W     = 15,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s0_valid,
    input  logic             s0_exc,
    input  logic [EXC_W-1:0] s0_exc_type,
    input  logic             s0_ertn,
    input  logic [31:0]      s0_pc,
    input  logic             s0_badv_valid,
    input  logic [31:0]      s0_badv,
    input  logic             s1_valid,
    input  logic             s1_exc,
    input  logic [EXC_W-1:0] s1_exc_type,
    input  logic             s1_ertn,
    input  logic [31:0]      s1_pc,
    input  logic             s1_badv_valid,
    input  logic [31:0]      s1_badv,
    input  logic             interrupt,
    input  logic [31:0]      csr_pc_out,
    output logic             csr_have_exception,
    output logic             csr_ertn,
    output logic [EXC_W-1:0] csr_exception_type,
    output logic [31:0]      csr_pc_in,
    output logic             csr_badv_we,
    output logic [31:0]      csr_badv_data,
    output logic             commit_stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
`ifdef EXC_COMMIT_CNT_EN
    output logic [31:0]      trap_count,
`endif
    input  logic             redirect_ready
);

    typedef enum logic [1:0] {IDLE, TRAP, FLUSH, REDIR} state_t;

    // Cycles still to spend in FLUSH after TRAP's own flush cycle.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYC > 1) ? 4'(FLUSH_CYC - 2) : 4'd0;

    state_t           state_r, state_nxt_s;
    logic [3:0]       cnt_r, cnt_nxt_s;
    logic             have_r, have_nxt_s;
    logic             ertn_r, ertn_nxt_s;
    logic [EXC_W-1:0] type_r, type_nxt_s;
    logic [31:0]      pc_in_r, pc_in_nxt_s;
    logic             badv_we_r, badv_we_nxt_s;
    logic [31:0]      badv_data_r, badv_data_nxt_s;
    logic             stall_r, stall_nxt_s;
    logic             flush_r, flush_nxt_s;
    logic             rvalid_r, rvalid_nxt_s;
    logic [31:0]      rpc_r, rpc_nxt_s;

    logic             ev_s;
    logic             ev_ertn_s;
    logic [EXC_W-1:0] ev_type_s;
    logic [31:0]      ev_pc_s;
    logic             ev_badv_we_s;
    logic [31:0]      ev_badv_s;

    // Strict-priority trap event selection; any slot-0 event masks slot 1.
    always_comb begin
        ev_s         = 1'b0;
        ev_ertn_s    = 1'b0;
        ev_type_s    = '0;
        ev_pc_s      = 32'h0;
        ev_badv_we_s = 1'b0;
        ev_badv_s    = 32'h0;
        if (interrupt && s0_valid) begin
            ev_s    = 1'b1;
            ev_pc_s = s0_pc;
        end else if (interrupt && s1_valid) begin
            ev_s    = 1'b1;
            ev_pc_s = s1_pc;
        end else if (s0_valid && s0_exc) begin
            ev_s         = 1'b1;
            ev_type_s    = s0_exc_type;
            ev_pc_s      = s0_pc;
            ev_badv_we_s = s0_badv_valid;
            ev_badv_s    = s0_badv_valid ? s0_badv : 32'h0;
        end else if (s0_valid && s0_ertn) begin
            ev_s      = 1'b1;
            ev_ertn_s = 1'b1;
            ev_pc_s   = s0_pc;
        end else if (s1_valid && s1_exc) begin
            ev_s         = 1'b1;
            ev_type_s    = s1_exc_type;
            ev_pc_s      = s1_pc;
            ev_badv_we_s = s1_badv_valid;
            ev_badv_s    = s1_badv_valid ? s1_badv : 32'h0;
        end else if (s1_valid && s1_ertn) begin
            ev_s      = 1'b1;
            ev_ertn_s = 1'b1;
            ev_pc_s   = s1_pc;
        end else begin
            ev_s = 1'b0;
        end
    end

    // Next-state logic and next values of every registered output.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        have_nxt_s      = 1'b0;
        ertn_nxt_s      = 1'b0;
        type_nxt_s      = '0;
        pc_in_nxt_s     = 32'h0;
        badv_we_nxt_s   = 1'b0;
        badv_data_nxt_s = 32'h0;
        rpc_nxt_s       = rpc_r;
        case (state_r)
            IDLE: begin
                if (ev_s) begin
                    state_nxt_s     = TRAP;
                    have_nxt_s      = 1'b1;
                    ertn_nxt_s      = ev_ertn_s;
                    type_nxt_s      = ev_type_s;
                    pc_in_nxt_s     = ev_pc_s;
                    badv_we_nxt_s   = ev_badv_we_s;
                    badv_data_nxt_s = ev_badv_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TRAP: begin
                // CSR target is sampled before the strobe updates ERA/EENTRY.
                rpc_nxt_s = csr_pc_out;
                if (FLUSH_CYC > 1) begin
                    state_nxt_s = FLUSH;
                    cnt_nxt_s   = FLUSH_LOAD;
                end else begin
                    state_nxt_s = REDIR;
                end
            end
            FLUSH: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = REDIR;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            REDIR: begin
                if (redirect_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REDIR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        flush_nxt_s  = (state_nxt_s == TRAP) || (state_nxt_s == FLUSH);
        stall_nxt_s  = (state_nxt_s != IDLE);
        rvalid_nxt_s = (state_nxt_s == REDIR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            have_r      <= 1'b0;
            ertn_r      <= 1'b0;
            type_r      <= '0;
            pc_in_r     <= 32'h0;
            badv_we_r   <= 1'b0;
            badv_data_r <= 32'h0;
            stall_r     <= 1'b0;
            flush_r     <= 1'b0;
            rvalid_r    <= 1'b0;
            rpc_r       <= 32'h0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            have_r      <= have_nxt_s;
            ertn_r      <= ertn_nxt_s;
            type_r      <= type_nxt_s;
            pc_in_r     <= pc_in_nxt_s;
            badv_we_r   <= badv_we_nxt_s;
            badv_data_r <= badv_data_nxt_s;
            stall_r     <= stall_nxt_s;
            flush_r     <= flush_nxt_s;
            rvalid_r    <= rvalid_nxt_s;
            rpc_r       <= rpc_nxt_s;
        end
    end

    assign csr_have_exception = have_r;
    assign csr_ertn           = ertn_r;
    assign csr_exception_type = type_r;
    assign csr_pc_in          = pc_in_r;
    assign csr_badv_we        = badv_we_r;
    assign csr_badv_data      = badv_data_r;
    assign commit_stall       = stall_r;
    assign flush              = flush_r;
    assign redirect_valid     = rvalid_r;
    assign redirect_pc        = rpc_r;

`ifdef EXC_COMMIT_CNT_EN
    logic [31:0] trap_count_r;

    // Count committed exception/interrupt traps; ertn is not counted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            trap_count_r <= 32'h0;
        end else if (have_r && !ertn_r) begin
            trap_count_r <= trap_count_r + 32'd1;
        end else begin
            trap_count_r <= trap_count_r;
        end
    end

    assign trap_count = trap_count_r;
`endif

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Exception/interrupt commit sequencer between the dual-issue commit stage and the CSR file.
- Each cycle it picks the single highest-priority trap event from two commit slots plus the pending-interrupt line, then drives the CSR trap-update strobes.
- It captures the redirect target from the CSR, holds a pipeline flush for a fixed drain window, and hands the new PC to fetch through a valid/ready handshake.
- It stalls commit while a trap is in flight.

Parameters:
- EXC_W, 15, width of exception type ({Ecode[5:0], EsubCode[8:0]}).
- FLUSH_CYC, 2, number of cycles flush stays high (legal range 1..15).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- s0_valid  in  1  slot 0 (older) instruction commits this cycle
- s0_exc  in  1  slot 0 carries an exception
- s0_exc_type  in  EXC_W  slot 0 exception type
- s0_ertn  in  1  slot 0 is ertn
- s0_pc  in  32  slot 0 PC
- s0_badv_valid  in  1  slot 0 exception has a bad vaddr
- s0_badv  in  32  slot 0 bad vaddr
- s1_valid, s1_exc, s1_exc_type, s1_ertn, s1_pc, s1_badv_valid, s1_badv  in  same widths  slot 1 (younger) equivalents
- interrupt  in  1  pending enabled interrupt from CSR
- csr_pc_out  in  32  CSR trap target (ERA when ertn, else EENTRY), combinational
- csr_have_exception  out  1  one-cycle trap strobe to CSR
- csr_ertn  out  1  qualifies strobe as ertn
- csr_exception_type  out  EXC_W  type written to ESTAT
- csr_pc_in  out  32  PC written to ERA
- csr_badv_we  out  1  BADV write enable
- csr_badv_data  out  32  BADV data
- commit_stall  out  1  commit stage must hold
- flush  out  1  kill all in-flight instructions
- redirect_valid  out  1  new fetch PC available
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- FSM states: IDLE, TRAP, FLUSH, REDIR.
- Reset (resetn=0 at a clock edge): state=IDLE; all outputs 0; flush counter 0. This applies from any state and abandons any trap in flight.
- Event selection in IDLE, combinational on the inputs, strict priority:
  1. interrupt with s0_valid: type 0, pc s0_pc.
  2. interrupt with only s1_valid: type 0, pc s1_pc.
  3. s0_valid&s0_exc.
  4. s0_valid&s0_ertn.
  5. s1_valid&s1_exc.
  6. s1_valid&s1_ertn.
  - Slot 1 is considered only if slot 0 raised no event. A slot-0 event kills slot 1 even if slot 1 is valid.
  - If both exc and ertn are set on one slot, exc wins.
  - Interrupt with no valid slot: no event; wait.
- IDLE with an event (cycle T): latch type, pc, ertn flag, and badv_we = (winner is an exception) & badv_valid. Go to TRAP.
- TRAP (T+1):
  - csr_have_exception=1.
  - csr_ertn = latched flag.
  - csr_pc_in, csr_exception_type, csr_badv_we/data driven from the latches. csr_exception_type=0 for ertn.
  - Capture csr_pc_out into redirect_pc this cycle, before the CSR updates.
  - flush=1. Go to FLUSH.
- FLUSH: flush=1 for FLUSH_CYC-1 further cycles, so flush is high FLUSH_CYC+... cycles total from T+1, i.e. exactly FLUSH_CYC cycles (FLUSH_CYC=1 skips FLUSH). Then go to REDIR.
- REDIR: redirect_valid=1 and redirect_pc held stable until redirect_ready=1. On the handshake cycle, go to IDLE; redirect_valid drops the next cycle.
- commit_stall = (state != IDLE). Slot inputs and interrupt are ignored outside IDLE. interrupt is a level signal and is re-evaluated on return to IDLE.
- All CSR strobes are single-cycle and registered; at most one trap is in flight.
- redirect_ready high before REDIR has no effect.

Optional Feature:
- Macro: EXC_COMMIT_CNT_EN.
- When defined:
  - Extra output trap_count[31:0], reset 0.
  - Increments by 1 on every cycle csr_have_exception=1 with csr_ertn=0.
  - Wraps 0xFFFFFFFF to 0.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- s0_valid=1, s0_exc=1, type=0x0C0 (15'h0C0), pc=0x1c000100, badv_valid=1, badv=0xdead0000, csr_pc_out=0x1c008000 -> T+1: strobe with pc_in=0x1c000100 and badv_we=1; flush high 2 cycles; redirect_pc=0x1c008000 held until ready.
- s0 exception and s1 ertn in the same cycle -> only the s0 exception is taken; csr_ertn=0 throughout.
- interrupt=1 with no valid slot for 3 cycles, then s1_valid=1, pc=0x1c000204 -> trap with type 0 and pc_in=0x1c000204; no action in the first 3 cycles.
- s0 ertn, csr_pc_out=0x1c000404 (ERA), redirect_ready held low 5 cycles -> redirect_valid stays high with a stable PC; commit_stall stays 1; a new s0_exc during the wait is ignored.
- resetn=0 during FLUSH -> next cycle all outputs 0 and state IDLE; a fresh exception afterwards is processed normally.
- EXC_COMMIT_CNT_EN: 3 exceptions and 1 ertn -> trap_count=3.
